// File: rtl/usb_rx_crc_ctrl.sv
// usb_rx_crc_ctrl
// Receive-side sequencer for the USB CRC5/CRC16 shift-register generator.
// It follows each packet from SOP to EOP, decodes the 8-bit PID and steers
// only the post-PID bits into the CRC register that matches the packet type.
// At EOP it checks the residual and the bit count, and reports a one-cycle
// result strobe with error flags.
//
// Ports:
//   clk, n_rst      clock, asynchronous active-low reset
//   sop, eop        one-cycle start / end of packet pulses
//   bit_valid       one destuffed bit is present on rx_bit this cycle
//   rx_bit          received bit, LSB first
//   crc5_in         generator CRC5 register
//   crc16_in        generator CRC16 register
//   CLEAR           clear both generator registers (follows sop)
//   shift_enable    advance the selected generator register
//   enable_CRC5     CRC5 register selected (token packets)
//   enable_CRC16    CRC16 register selected (data packets)
//   pid             PID[3:0] of the last decoded packet
//   done            one-cycle result strobe
//   crc_err         nonzero residual, valid with done
//   len_err         illegal bit count, valid with done
//   pid_err         bad / unsupported PID or EOP inside the PID, valid with done
//
// Handshake: there is no back-pressure. sop, eop and bit_valid are
// single-cycle qualifiers sampled on the rising clock edge; a bit_valid in the
// same cycle as sop or eop is discarded. done is a single-cycle strobe and the
// error flags hold their value until the next done.
module usb_rx_crc_ctrl #(
  parameter int MAX_DATA_BYTES = 64,
  parameter int CNT_W          = 11
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        sop,
  input  logic        eop,
  input  logic        bit_valid,
  input  logic        rx_bit,
  input  logic [4:0]  crc5_in,
  input  logic [15:0] crc16_in,
  output logic        CLEAR,
  output logic        shift_enable,
  output logic        enable_CRC5,
  output logic        enable_CRC16,
  output logic [3:0]  pid,
  output logic        done,
  output logic        crc_err,
  output logic        len_err,
  output logic        pid_err
);

  // Largest legal post-PID bit count: payload plus the two CRC bytes.
  localparam int MAX_BITS = 8 * (MAX_DATA_BYTES + 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PID,
    S_TOKEN,
    S_DATA,
    S_HSHAKE,
    S_SKIP,
    S_CHECK
  } state_t;

  state_t             state, state_nx;
  // Remembers which packet state led into CHECK so the right checks are applied.
  state_t             src, src_nx;
  logic [7:0]         pid_sr, pid_sr_nx;
  logic [2:0]         pid_cnt, pid_cnt_nx;
  logic [CNT_W-1:0]   bit_cnt, bit_cnt_nx;
  logic               ovf, ovf_nx;
  logic [3:0]         pid_nx;
  logic               done_nx, crc_err_nx, len_err_nx, pid_err_nx;

  logic [7:0]         pid_shift;
  logic [CNT_W-1:0]   cnt_inc;

  // PID bits arrive LSB first, so new bits enter at the top.
  assign pid_shift = {rx_bit, pid_sr[7:1]};
  // Saturating increment; overflow is tracked separately by ovf.
  assign cnt_inc   = (bit_cnt == {CNT_W{1'b1}}) ? bit_cnt : bit_cnt + CNT_W'(1);

  function automatic state_t decode_pid(input logic [7:0] p);
    state_t r;
    if (p[7:4] != ~p[3:0]) begin
      r = S_SKIP;
    end else if (p[1:0] == 2'b01 || p[3:0] == 4'b0100) begin
      r = S_TOKEN;  // OUT/IN/SOF/SETUP and PING carry a CRC5
    end else if (p[1:0] == 2'b11) begin
      r = S_DATA;
    end else if (p[1:0] == 2'b10) begin
      r = S_HSHAKE;
    end else begin
      r = S_SKIP;   // remaining special PIDs are not supported
    end
    return r;
  endfunction

  // Generator control is purely a function of the current state and strobes.
  assign CLEAR        = sop;
  assign shift_enable = bit_valid & ((state == S_TOKEN) | (state == S_DATA)) & ~eop & ~sop;
  assign enable_CRC5  = (state == S_TOKEN);
  assign enable_CRC16 = (state == S_DATA);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state   <= S_IDLE;
      src     <= S_IDLE;
      pid_sr  <= '0;
      pid_cnt <= '0;
      bit_cnt <= '0;
      ovf     <= 1'b0;
      pid     <= '0;
      done    <= 1'b0;
      crc_err <= 1'b0;
      len_err <= 1'b0;
      pid_err <= 1'b0;
    end else begin
      state   <= state_nx;
      src     <= src_nx;
      pid_sr  <= pid_sr_nx;
      pid_cnt <= pid_cnt_nx;
      bit_cnt <= bit_cnt_nx;
      ovf     <= ovf_nx;
      pid     <= pid_nx;
      done    <= done_nx;
      crc_err <= crc_err_nx;
      len_err <= len_err_nx;
      pid_err <= pid_err_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    src_nx     = src;
    pid_sr_nx  = pid_sr;
    pid_cnt_nx = pid_cnt;
    bit_cnt_nx = bit_cnt;
    ovf_nx     = ovf;
    pid_nx     = pid;
    done_nx    = 1'b0;
    crc_err_nx = crc_err;
    len_err_nx = len_err;
    pid_err_nx = pid_err;

    if (sop) begin
      // sop always restarts, including an abort of a packet in progress.
      state_nx   = S_PID;
      pid_sr_nx  = '0;
      pid_cnt_nx = '0;
      bit_cnt_nx = '0;
      ovf_nx     = 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
        end

        S_PID: begin
          if (eop) begin
            state_nx = S_CHECK;
            src_nx   = S_PID;
          end else if (bit_valid) begin
            pid_sr_nx  = pid_shift;
            pid_cnt_nx = pid_cnt + 3'd1;
            if (pid_cnt == 3'd7) begin
              pid_nx   = pid_shift[3:0];
              state_nx = decode_pid(pid_shift);
            end
          end
        end

        S_TOKEN, S_DATA: begin
          if (eop) begin
            state_nx = S_CHECK;
            src_nx   = state;
          end else if (bit_valid) begin
            bit_cnt_nx = cnt_inc;
            if ({{(32 - CNT_W){1'b0}}, cnt_inc} > 32'(MAX_BITS)) begin
              ovf_nx = 1'b1;
            end
          end
        end

        S_HSHAKE: begin
          if (eop) begin
            state_nx = S_CHECK;
            src_nx   = S_HSHAKE;
          end else if (bit_valid) begin
            bit_cnt_nx = cnt_inc;
          end
        end

        S_SKIP: begin
          if (eop) begin
            state_nx = S_CHECK;
            src_nx   = S_SKIP;
          end
        end

        S_CHECK: begin
          state_nx   = S_IDLE;
          done_nx    = 1'b1;
          crc_err_nx = 1'b0;
          len_err_nx = 1'b0;
          pid_err_nx = 1'b0;
          case (src)
            S_TOKEN: begin
              len_err_nx = (bit_cnt != CNT_W'(16));
              crc_err_nx = (crc5_in != 5'd0);
            end
            S_DATA: begin
              len_err_nx = (bit_cnt < CNT_W'(16)) | (bit_cnt[2:0] != 3'd0) | ovf;
              crc_err_nx = (crc16_in != 16'd0);
            end
            S_HSHAKE: begin
              len_err_nx = (bit_cnt != '0);
            end
            S_PID: begin
              pid_err_nx = 1'b1;
              len_err_nx = 1'b1;
            end
            default: begin
              pid_err_nx = 1'b1;  // SKIP: bad or unsupported PID
            end
          endcase
        end

        default: state_nx = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_rx_crc_ctrl.sv
// Testbench for usb_rx_crc_ctrl. Includes a behavioural model of the external
// CRC5/CRC16 generator (MSB-first LFSRs, zero initialised, reciprocal USB
// polynomials) driven by the DUT's control outputs. Each packet's expected
// result word {shift count, pid, crc_err, len_err, pid_err} and the cycle of
// its done strobe are queued when eop is driven, and popped when done appears.
module tb_usb_rx_crc_ctrl;

  localparam int W = 19;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        sop = 1'b0, eop = 1'b0, bit_valid = 1'b0, rx_bit = 1'b0;
  logic [4:0]  crc5_in;
  logic [15:0] crc16_in;
  logic        CLEAR, shift_enable, enable_CRC5, enable_CRC16;
  logic [3:0]  pid;
  logic        done, crc_err, len_err, pid_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [W-1:0] exp_q[$];
  int           exp_cyc_q[$];
  logic         bq[$];

  usb_rx_crc_ctrl #(.MAX_DATA_BYTES(64), .CNT_W(11)) dut (
    .clk(clk), .n_rst(n_rst), .sop(sop), .eop(eop), .bit_valid(bit_valid),
    .rx_bit(rx_bit), .crc5_in(crc5_in), .crc16_in(crc16_in), .CLEAR(CLEAR),
    .shift_enable(shift_enable), .enable_CRC5(enable_CRC5),
    .enable_CRC16(enable_CRC16), .pid(pid), .done(done), .crc_err(crc_err),
    .len_err(len_err), .pid_err(pid_err)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- CRC generator model ----------------
  function automatic logic [4:0] next5(input logic [4:0] c, input logic b);
    return {c[3:0], 1'b0} ^ ((b ^ c[4]) ? 5'h09 : 5'h00);
  endfunction

  function automatic logic [15:0] next16(input logic [15:0] c, input logic b);
    return {c[14:0], 1'b0} ^ ((b ^ c[15]) ? 16'h4003 : 16'h0000);
  endfunction

  logic [4:0]  g5 = '0;
  logic [15:0] g16 = '0;
  logic [11:0] sh_cnt = '0;
  assign crc5_in  = g5;
  assign crc16_in = g16;

  always @(posedge clk) begin
    if (CLEAR) begin
      g5 <= '0; g16 <= '0; sh_cnt <= '0;
    end else if (shift_enable) begin
      sh_cnt <= sh_cnt + 12'd1;
      if (enable_CRC5)  g5  <= next5(g5, rx_bit);
      if (enable_CRC16) g16 <= next16(g16, rx_bit);
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (n_rst && done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'(cyc), 32'hFFFF_FFFF);
      end else begin
        chk("done_cycle", 32'(cyc), 32'(exp_cyc_q.pop_front()));
        chk("result", 32'({sh_cnt, pid, crc_err, len_err, pid_err}), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic s, input logic e, input logic v, input logic b);
    @(posedge clk);
    #1;
    sop = s; eop = e; bit_valid = v; rx_bit = b;
  endtask

  task automatic send_bit(input logic b);
    if ($urandom_range(0, 3) == 0) drive(1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, b);
  endtask

  task automatic start_pkt(input logic [7:0] p);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    #1 chk("clear_on_sop", 32'(CLEAR), 32'd1);
    for (int i = 0; i < 8; i++) send_bit(p[i]);
  endtask

  task automatic send_bq();
    foreach (bq[i]) send_bit(bq[i]);
  endtask

  task automatic add_crc5();
    logic [4:0] c = '0;
    foreach (bq[i]) c = next5(c, bq[i]);
    for (int i = 4; i >= 0; i--) bq.push_back(c[i]);
  endtask

  task automatic add_crc16();
    logic [15:0] c = '0;
    foreach (bq[i]) c = next16(c, bq[i]);
    for (int i = 15; i >= 0; i--) bq.push_back(c[i]);
  endtask

  task automatic fill(input int n, input logic rnd);
    bq.delete();
    for (int i = 0; i < n; i++) bq.push_back(rnd ? 1'($urandom_range(0, 1)) : 1'b0);
  endtask

  // eop with an optional same-cycle bit that must be dropped.
  task automatic finish_pkt(input logic [11:0] sh, input logic [3:0] p,
                            input logic ce, input logic le, input logic pe,
                            input logic stray);
    drive(1'b0, 1'b1, stray, stray);
    exp_q.push_back({sh, p, ce, le, pe});
    exp_cyc_q.push_back(cyc + 2);
    repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic good_token();
    start_pkt(8'hE1);
    fill(10, 1'b0); bq.push_back(1'b1); add_crc5();
    send_bq();
    finish_pkt(12'd16, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    #2;
    chk("reset_outputs", 32'({CLEAR, shift_enable, enable_CRC5, enable_CRC16, pid,
                             done, crc_err, len_err, pid_err}), 32'd0);
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;
    repeat (2) drive(1'b0, 1'b0, 1'b0, 1'b0);

    // Token OUT with the canonical CRC5 bits 0,1,0,0,1; stray bit on eop dropped.
    start_pkt(8'hE1);
    fill(10, 1'b0); bq.push_back(1'b1); add_crc5();
    chk("crc5_bits", 32'({bq[11], bq[12], bq[13], bq[14], bq[15]}), 32'b01001);
    send_bq();
    finish_pkt(12'd16, 4'h1, 1'b0, 1'b0, 1'b0, 1'b1);

    // Same token with the 4th data bit flipped.
    start_pkt(8'hE1);
    fill(10, 1'b0); bq.push_back(1'b1); add_crc5();
    bq[3] = ~bq[3];
    send_bq();
    finish_pkt(12'd16, 4'h1, 1'b1, 1'b0, 1'b0, 1'b0);

    // DATA0, two zero bytes, CRC 0x0000.
    start_pkt(8'hC3);
    fill(16, 1'b0); add_crc16(); send_bq();
    finish_pkt(12'd32, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0);

    // Same with 3 extra bits.
    start_pkt(8'hC3);
    fill(35, 1'b0); send_bq();
    finish_pkt(12'd35, 4'h3, 1'b0, 1'b1, 1'b0, 1'b0);

    // ACK, then a PID whose check nibble is wrong.
    start_pkt(8'hD2);
    finish_pkt(12'd0, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0);
    start_pkt(8'hF1);
    finish_pkt(12'd0, 4'h1, 1'b0, 1'b0, 1'b1, 1'b0);

    // Abort mid-DATA after 20 bits, restart with a random DATA1 packet.
    start_pkt(8'hC3);
    fill(20, 1'b0); send_bq();
    start_pkt(8'h4B);
    fill(24, 1'b1); add_crc16(); send_bq();
    finish_pkt(12'd40, 4'hB, 1'b0, 1'b0, 1'b0, 1'b0);

    // eop after 3 PID bits; pid keeps the previous packet's value.
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    finish_pkt(12'd0, 4'hB, 1'b0, 1'b1, 1'b1, 1'b0);

    // PING with random address/endpoint.
    start_pkt(8'hB4);
    fill(11, 1'b1); add_crc5(); send_bq();
    finish_pkt(12'd16, 4'h4, 1'b0, 1'b0, 1'b0, 1'b0);

    // Largest legal data packet: 64 random bytes + CRC.
    start_pkt(8'hC3);
    fill(512, 1'b1); add_crc16(); send_bq();
    finish_pkt(12'd528, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0);

    // One byte too many: overflow.
    start_pkt(8'hC3);
    fill(536, 1'b0); send_bq();
    finish_pkt(12'd536, 4'h3, 1'b0, 1'b1, 1'b0, 1'b0);

    // Too short to hold a CRC16.
    start_pkt(8'hC3);
    fill(8, 1'b0); send_bq();
    finish_pkt(12'd8, 4'h3, 1'b0, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset mid-token.
    start_pkt(8'hE1);
    fill(5, 1'b1); send_bq();
    chk("in_token", 32'(enable_CRC5), 32'd1);
    @(posedge clk);
    #1;
    bit_valid = 1'b1; rx_bit = 1'b1; n_rst = 1'b0;
    #1 chk("async_reset", 32'({CLEAR, shift_enable, enable_CRC5, enable_CRC16, pid,
                                done, crc_err, len_err, pid_err}), 32'd0);
    bit_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;
    repeat (2) drive(1'b0, 1'b0, 1'b0, 1'b0);
    good_token();

    repeat (5) drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("pending_results", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/usb_rx_crc_ctrl.md
Name: usb_rx_crc_ctrl

Overview:
- Receive-side sequencer for the CRC5/CRC16 shift-register generator in the USB receiver.
- Tracks each packet from start-of-packet (SOP) to end-of-packet (EOP) and decodes the PID.
- Routes only post-PID bits into the correct CRC register by driving the generator's CLEAR, shift_enable, enable_CRC5 and enable_CRC16.
- At EOP, checks the zero residual and the packet length, then reports a one-cycle result to the receive FSM.

Parameters:
- MAX_DATA_BYTES, 64: maximum data payload bytes, excluding the 2 CRC bytes.
- CNT_W, 11: width of the post-PID bit counter. Must be at least clog2(8*(MAX_DATA_BYTES+2)+1).

Ports:
- clk  input  1  system clock.
- n_rst  input  1  asynchronous, active-low reset.
- sop  input  1  one-cycle pulse: sync field done, the next bit_valid is PID bit 0.
- eop  input  1  one-cycle pulse: end of packet.
- bit_valid  input  1  one-cycle strobe: one destuffed bit available on rx_bit.
- rx_bit  input  1  received bit, LSB first. Same net as the generator's D_plus_sync.
- crc5_in  input  5  generator CRC5 register.
- crc16_in  input  16  generator CRC16 register.
- CLEAR  output  1  clear both CRC registers.
- shift_enable  output  1  advance the selected CRC register.
- enable_CRC5  output  1  select CRC5.
- enable_CRC16  output  1  select CRC16.
- pid  output  4  PID[3:0] of the last packet.
- done  output  1  one-cycle result strobe.
- crc_err  output  1  CRC residual nonzero. Valid with done.
- len_err  output  1  illegal bit count. Valid with done.
- pid_err  output  1  PID check failed, unsupported PID, or EOP inside PID. Valid with done.

Behaviour:
- Reset: state IDLE, counters 0, pid=0, done/crc_err/len_err/pid_err=0. CLEAR, shift_enable, enable_CRC5 and enable_CRC16 are all 0.
- Outputs from the state register:
  - CLEAR = sop (combinational).
  - shift_enable = bit_valid & (state==TOKEN | state==DATA) & ~eop & ~sop.
  - enable_CRC5 = (state==TOKEN).
  - enable_CRC16 = (state==DATA).
- CRC convention:
  - Zero-initialised, uncomplemented.
  - Transmitter appends the remainder MSB first.
  - A good packet leaves residual 0 in the selected register.
- IDLE:
  - sop -> PID, pid_cnt=0.
  - eop and bit_valid are ignored.
- PID (8 bits, assembled LSB first into pid_sr):
  - The 8th bit_valid moves to the next state as follows.
  - pid_sr[7:4] != ~pid_sr[3:0] -> SKIP with pid_err pending.
  - Type [1:0]=01 (token), or PID 4'b0100 (PING) -> TOKEN.
  - Type 11 -> DATA.
  - Type 10 -> HSHAKE.
  - Other type-00 PIDs -> SKIP with pid_err pending.
  - pid output updates to pid_sr[3:0] on that edge.
- TOKEN / DATA:
  - Each bit_valid increments bit_cnt, which saturates at its maximum.
  - bit_cnt > 8*(MAX_DATA_BYTES+2) sets ovf.
- HSHAKE: each bit_valid increments bit_cnt.
- SKIP: bits are ignored and the CRC is not shifted.
- eop in PID, TOKEN, DATA, HSHAKE or SKIP -> CHECK. A bit_valid in the same cycle as eop is dropped.
- CHECK lasts exactly one cycle. It registers done=1 and the error flags, then goes to IDLE:
  - TOKEN: len_err = (bit_cnt!=16); crc_err = (crc5_in!=0).
  - DATA: len_err = (bit_cnt<16 | bit_cnt[2:0]!=0 | ovf); crc_err = (crc16_in!=0).
  - HSHAKE: len_err = (bit_cnt!=0); crc_err=0.
  - PID (EOP before 8 bits): pid_err=1, len_err=1.
  - SKIP: pid_err=1.
- done latency: eop sampled at edge k -> done high for exactly one cycle, from edge k+1 to edge k+2. Flags are held until the next done.
- sop in any state other than IDLE aborts the packet: CLEAR=1, go to PID, counters reset, no done.
- sop and eop in the same cycle: sop wins.
- Asynchronous reset mid-packet returns to IDLE immediately with all reset values. No done is produced.

Test Plan:
- Token OUT: PID 0xE1, then 10 zeros, 1, then CRC bits 0,1,0,0,1, then eop -> enable_CRC5=1 for 16 shifts, residual 0. done with crc_err=0, len_err=0, pid_err=0, pid=4'h1.
- Same token with the 4th data bit flipped -> done with crc_err=1, len_err=0.
- DATA0: PID 0xC3, 2 zero payload bytes, CRC 0x0000, eop -> enable_CRC16 for 32 shifts, done with all flags 0, pid=4'h3. Same packet with 3 extra bits -> len_err=1.
- ACK: PID 0xD2 then eop -> shift_enable never asserted, done with flags 0. Bad PID 0xF1 -> pid_err=1, no shifts.
- Abort: sop mid-DATA after 20 bits -> CLEAR pulse, no done, bit_cnt restarts. eop after 3 PID bits -> pid_err=1, len_err=1.
- Assert n_rst low mid-TOKEN -> all outputs 0 asynchronously. The next valid token passes cleanly.
